delay_timer_arbiter: RTL and testbench
======================================

Name: delay_timer_arbiter

Overview:
- Shares one delay-timer block (trigger/mode in, "counter free" flag out) among N_REQ requesters.
- Grants access round-robin and issues a one-cycle trigger with the winner's mode.
- Tracks the timer through busy and free, then returns a one-cycle done pulse to the winner.
- Sits between requesting control FSMs and the single timer instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 4, max cycles after the trigger to wait for cf to go low before flagging an error.
- CNT_W, 3, width of the timeout counter; must hold BUSY_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester level request; held until the matching done.
- req_long  input  N_REQ  per-requester mode select (1 = long/3x delay, 0 = short); sampled at grant.
- grant  output  N_REQ  one-hot; owner of the timer; high from ISSUE through DONE.
- done  output  N_REQ  one-cycle pulse to the served requester.
- tr  output  1  trigger to the timer, one-cycle pulse.
- mode  output  1  mode to the timer; valid while tr = 1, held until the next issue.
- cf  input  1  timer free flag (1 = idle, 0 = counting).
- err  output  1  sticky: timer failed to go busy within BUSY_TIMEOUT.

Behaviour:
- Reset:
  - reset_n = 0 asynchronously clears all state: state = IDLE, RR pointer = 0, grant = 0, done = 0, tr = 0, mode = 0, err = 0, timeout count = 0.
  - Reset mid-transaction abandons it; no done pulse is issued.
- Outputs: all registered; no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_FREE, DONE.
- IDLE:
  - If cf = 1 and req != 0, select the winner by round-robin starting at the RR pointer, ascending and wrapping modulo N_REQ.
  - Latch the winner id and req_long[id], then go to ISSUE.
  - If cf = 0, stay in IDLE; this covers a timer still busy after our own reset.
- ISSUE (exactly 1 cycle):
  - tr = 1, mode = latched mode, grant[id] = 1.
  - Go to WAIT_BUSY; clear the timeout count.
- WAIT_BUSY:
  - cf = 0: go to WAIT_FREE.
  - Else increment the count. When the count reaches BUSY_TIMEOUT, set err = 1 and go to DONE.
- WAIT_FREE: wait for cf = 1, then go to DONE. There is no upper bound.
- DONE (exactly 1 cycle):
  - done[id] = 1, grant[id] still 1.
  - RR pointer = (id + 1) mod N_REQ. Go to IDLE.
  - grant drops to 0 on the next cycle.
- Latency:
  - req first high in IDLE with cf = 1 at cycle c gives tr/grant high in cycle c+1.
  - Back-to-back requests: next tr no earlier than 2 cycles after done (DONE -> IDLE -> ISSUE).
- Requester rules:
  - Dropping req after grant does not cancel; the transaction completes and done still pulses.
  - req still high in the cycle after done is treated as a new request.
  - Requesters deassert on done to avoid a repeat.
- Simultaneous requests: only the round-robin winner is served; the others stay pending with no loss and no starvation. Worst-case wait is N_REQ - 1 transactions.
- Input sampling:
  - req_long changes after the grant are ignored.
  - req and req_long of non-granted requesters are ignored until IDLE.
- err: sticky until reset_n; it does not block further arbitration.
- Invariants: grant is one-hot or zero; at most one done bit is high; tr is high only in ISSUE.

Test Plan:
- Single request: req = 4'b0001, req_long = 0 at cycle 1 (IDLE, cf = 1).
  - tr = 1, mode = 0, grant = 0001 at cycle 2.
  - cf held 0 for cycles 4..7 then 1: done = 0001 exactly one cycle after cf is sampled 1; grant = 0 the cycle after that.
- Long mode: req = 4'b0100, req_long = 4'b0100 -> mode = 1 with tr; grant = 0100; done = 0100 after cf returns to 1.
- Round-robin: req = 4'b1111 held continuously from reset.
  - Grant order is 0001, 0010, 0100, 1000, 0001.
  - Each requester drops req on its done and re-raises one cycle later.
- Timeout: req = 4'b0010, cf stuck at 1.
  - err = 1 and done = 0010 after BUSY_TIMEOUT = 4 cycles in WAIT_BUSY.
  - err stays 1; a following req = 0001 is still served normally.
- Reset mid-operation: assert reset_n = 0 while in WAIT_FREE.
  - grant, tr, done and err read 0 immediately and asynchronously.
  - After release with cf = 0, a pending req is not issued until cf = 1.
- Early drop: req = 4'b1000 deasserted one cycle after the grant -> transaction still completes with a done = 1000 pulse.

Source files
------------

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one delay timer: issue is 1 cycle after a winning request, done 1 cycle after cf returns high.
// Losers hold req and stay pending; cf low in IDLE stalls arbitration until the timer is free.
module delay_timer_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_long,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             tr,
  output logic             mode,
  input  logic             cf,
  output logic             err
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_FREE,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, ptr_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;
  logic [ID_W-1:0]   win_id, cand;
  logic              win_vld;
  logic              mode_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_nxt;
  logic              tr_nxt;
  logic [N_REQ-1:0]  grant_nxt, done_nxt;

  // First requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = rr_ptr;
    cand    = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    id_nxt    = id_q;
    mode_nxt  = mode;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (cf && win_vld) begin
          id_nxt    = win_id;
          mode_nxt  = req_long[win_id];
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!cf) begin
          state_nxt = WAIT_FREE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt_nxt == CNT_W'(BUSY_TIMEOUT)) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      WAIT_FREE: begin
        if (cf) state_nxt = DONE;
      end
      DONE: begin
        ptr_nxt   = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered.
    tr_nxt    = (state_nxt == ISSUE);
    grant_nxt = '0;
    done_nxt  = '0;
    if (state_nxt != IDLE) grant_nxt = N_REQ'(1) << id_nxt;
    if (state_nxt == DONE) done_nxt = N_REQ'(1) << id_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      mode   <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
      tr     <= 1'b0;
      grant  <= '0;
      done   <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= ptr_nxt;
      id_q   <= id_nxt;
      mode   <= mode_nxt;
      cnt    <= cnt_nxt;
      err    <= err_nxt;
      tr     <= tr_nxt;
      grant  <= grant_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Scoreboard bench for delay_timer_arbiter: stimulus pushes expected issue/done records, a negedge monitor pops and compares.
module tb_delay_timer_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] req_long = 4'b0000;
  logic [3:0] grant, done;
  logic       tr, mode, err;
  logic       cf;

  // cf comes either from a small timer model or from a directed override.
  logic cf_ovr = 1'b0;
  logic cf_val = 1'b1;
  logic timer_cf = 1'b1;
  int   tcnt = 0;
  assign cf = cf_ovr ? cf_val : timer_cf;

  typedef struct {
    logic [3:0] v;
    logic       b;
    int         cyc;
  } exp_t;

  exp_t q_iss[$];
  exp_t q_done[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   c0, c1;
  logic       auto_rr = 1'b0;
  int         rr_left = 0;
  logic [3:0] pend = 4'b0000;
  logic [3:0] prev_done = 4'b0000;

  delay_timer_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(4), .CNT_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_long (req_long),
    .grant    (grant),
    .done     (done),
    .tr       (tr),
    .mode     (mode),
    .cf       (cf),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] v, input logic b, input int c);
    exp_t e;
    e.v = v;
    e.b = b;
    e.cyc = c;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (q_iss.size() == 0 && q_done.size() == 0) break;
      step();
    end
    chk("drain_pending", q_iss.size() + q_done.size(), 0);
    step();
  endtask

  // Requesters drop on done; in round-robin mode they re-raise a cycle later.
  // Timer model: cf low for 3 (short) or 9 (long) cycles after each trigger.
  always begin
    @(posedge clk);
    #1;
    if (reset_n) begin
      req  = req | pend;
      pend = 4'b0000;
      if (done != 4'b0000) begin
        req = req & ~done;
        if (auto_rr) begin
          rr_left--;
          if (rr_left == 0) begin
            auto_rr = 1'b0;
            req = 4'b0000;
          end else begin
            pend = done;
          end
        end
      end
    end
    if (tr && !cf_ovr) begin
      tcnt = mode ? 9 : 3;
      timer_cf = 1'b0;
    end else if (tcnt > 0) begin
      tcnt--;
      if (tcnt == 0) timer_cf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_done != 4'b0000) chk("grant_after_done", grant, 0);
      if (tr) begin
        if (q_iss.size() == 0) begin
          chk("unexpected_tr", tr, 0);
        end else begin
          me = q_iss.pop_front();
          chk("tr_grant", grant, me.v);
          chk("tr_mode", mode, me.b);
          if (me.cyc >= 0) chk("tr_cycle", cyc, me.cyc);
        end
      end
      if (done != 4'b0000) begin
        if (q_done.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          me = q_done.pop_front();
          chk("done_val", done, me.v);
          chk("done_grant", grant, me.v);
          chk("done_err", err, me.b);
          if (me.cyc >= 0) chk("done_cycle", cyc, me.cyc);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 4'b0000;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset with all four requesting; round-robin from pointer 0.
    #1;
    reset_n  = 1'b0;
    req      = 4'b1111;
    req_long = 4'b0010;
    auto_rr  = 1'b1;
    rr_left  = 5;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_tr", tr, 0);
    chk("rst_mode", mode, 0);
    chk("rst_err", err, 0);
    q_iss.push_back(mk(4'b0001, 1'b0, -1));
    q_iss.push_back(mk(4'b0010, 1'b1, -1));
    q_iss.push_back(mk(4'b0100, 1'b0, -1));
    q_iss.push_back(mk(4'b1000, 1'b0, -1));
    q_iss.push_back(mk(4'b0001, 1'b0, -1));
    q_done.push_back(mk(4'b0001, 1'b0, -1));
    q_done.push_back(mk(4'b0010, 1'b0, -1));
    q_done.push_back(mk(4'b0100, 1'b0, -1));
    q_done.push_back(mk(4'b1000, 1'b0, -1));
    q_done.push_back(mk(4'b0001, 1'b0, -1));
    step();
    step();
    reset_n = 1'b1;
    wait_drain(400);
    req_long = 4'b0000;

    // Single short request with cf low for four cycles starting 3 after the request.
    cf_ovr = 1'b1;
    cf_val = 1'b1;
    step();
    c0  = cyc;
    req = 4'b0001;
    q_iss.push_back(mk(4'b0001, 1'b0, c0 + 1));
    q_done.push_back(mk(4'b0001, 1'b0, c0 + 8));
    step();
    step();
    step();
    cf_val = 1'b0;
    repeat (4) step();
    cf_val = 1'b1;
    wait_drain(40);

    // Long mode through the timer model.
    cf_ovr   = 1'b0;
    req_long = 4'b0100;
    c0  = cyc;
    req = 4'b0100;
    q_iss.push_back(mk(4'b0100, 1'b1, c0 + 1));
    q_done.push_back(mk(4'b0100, 1'b0, -1));
    step();
    req_long = 4'b0000;
    wait_drain(60);

    // Requester drops req the cycle after its grant; done must still come.
    c0  = cyc;
    req = 4'b1000;
    q_iss.push_back(mk(4'b1000, 1'b0, c0 + 1));
    q_done.push_back(mk(4'b1000, 1'b0, -1));
    step();
    step();
    req = 4'b0000;
    wait_drain(60);

    // Timer never goes busy: done with err after four cycles in WAIT_BUSY.
    cf_ovr = 1'b1;
    cf_val = 1'b1;
    c0  = cyc;
    req = 4'b0010;
    q_iss.push_back(mk(4'b0010, 1'b0, c0 + 1));
    q_done.push_back(mk(4'b0010, 1'b1, c0 + 6));
    wait_drain(40);
    chk("err_set", err, 1);
    cf_ovr = 1'b0;
    c0  = cyc;
    req = 4'b0001;
    q_iss.push_back(mk(4'b0001, 1'b0, c0 + 1));
    q_done.push_back(mk(4'b0001, 1'b1, -1));
    wait_drain(60);
    chk("err_sticky", err, 1);

    // Asynchronous reset while waiting for the timer to become free.
    cf_ovr = 1'b1;
    cf_val = 1'b1;
    c0  = cyc;
    req = 4'b0100;
    q_iss.push_back(mk(4'b0100, 1'b0, c0 + 1));
    q_done.push_back(mk(4'b0100, 1'b0, -1));
    step();
    step();
    cf_val = 1'b0;
    step();
    step();
    chk("wf_grant", grant, 4'b0100);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_tr", tr, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    q_done.delete();
    req = 4'b0001;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_tr_cf0", tr, 0);
      chk("hold_grant_cf0", grant, 0);
    end
    c1 = cyc;
    cf_val = 1'b1;
    q_iss.push_back(mk(4'b0001, 1'b0, c1 + 1));
    q_done.push_back(mk(4'b0001, 1'b0, -1));
    step();
    step();
    cf_val = 1'b0;
    step();
    cf_val = 1'b1;
    wait_drain(40);

    chk("queues_empty", q_iss.size() + q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
